mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-style control unit.
// Sequences fetch/decode/execute/memory/writeback states from the opcode and
// funct fields, and drives datapath enables, mux selects and the ALU op code.
// Optional feature: define MC_CTRL_IO_WAIT_EN to add I/O wait-state handling
// (is_io / io_ready inputs, IOWAIT state and a 16-cycle stall timeout).
module mc_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
`ifdef MC_CTRL_IO_WAIT_EN
    input  logic       is_io,
    input  logic       io_ready,
`endif
    output logic       pc_en,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [3:0] alu_ctrl,
    output logic       error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_AEX    = 4'd9,
        S_AWB    = 4'd10,
        S_JMP    = 4'd11
`ifdef MC_CTRL_IO_WAIT_EN
        ,
        S_IOWAIT = 4'd12
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1010;

    // R-type funct decode; unknown codes fall back to add.
    function automatic logic [3:0] funct_to_alu(input logic [5:0] f);
        logic [3:0] a;
        case (f)
            6'b100000: a = ALU_ADD;
            6'b100010: a = ALU_SUB;
            6'b100100: a = ALU_AND;
            6'b100101: a = ALU_OR;
            6'b100110: a = ALU_XOR;
            6'b100111: a = ALU_NOR;
            6'b101010: a = ALU_SLT;
            default:   a = ALU_ADD;
        endcase
        return a;
    endfunction

    function automatic logic funct_legal(input logic [5:0] f);
        logic ok;
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b101010: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_e state_q, state_d;
    logic   error_q, error_d;
`ifdef MC_CTRL_IO_WAIT_EN
    logic [3:0] stall_cnt_q, stall_cnt_d;
`endif

    logic       pc_en_s, ir_write_s, mem_write_s, reg_write_s;
    logic       iord_s, reg_dst_s, mem_to_reg_s, alu_src_a_s;
    logic [1:0] alu_src_b_s, pc_src_s;
    logic [3:0] alu_ctrl_s;

    // State, sticky error and stall counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_FETCH;
            error_q     <= 1'b0;
`ifdef MC_CTRL_IO_WAIT_EN
            stall_cnt_q <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            error_q     <= error_d;
`ifdef MC_CTRL_IO_WAIT_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    // Next-state sequencing and error capture.
    always_comb begin
        state_d     = state_q;
        error_d     = error_q;
`ifdef MC_CTRL_IO_WAIT_EN
        stall_cnt_d = stall_cnt_q;
`endif
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_AEX;
                    OP_J:         state_d = S_JMP;
                    default: begin
                        state_d = S_FETCH;
                        error_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
`ifdef MC_CTRL_IO_WAIT_EN
            S_MEMRD: begin
                if (is_io && !io_ready) begin
                    state_d     = S_IOWAIT;
                    stall_cnt_d = 4'd0;
                end else begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWR: begin
                if (is_io && !io_ready) begin
                    state_d     = S_IOWAIT;
                    stall_cnt_d = 4'd0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            // The held access is identified by the opcode still in IR.
            S_IOWAIT: begin
                if (io_ready || (stall_cnt_q == 4'd15)) begin
                    state_d     = (op == OP_SW) ? S_FETCH : S_MEMWB;
                    stall_cnt_d = 4'd0;
                    if (!io_ready) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = error_q;
                    end
                end else begin
                    stall_cnt_d = stall_cnt_q + 4'd1;
                end
            end
`else
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWR:  state_d = S_FETCH;
`endif
            S_MEMWB:  state_d = S_FETCH;
            S_REX: begin
                if (funct_legal(funct)) begin
                    state_d = S_RWB;
                end else begin
                    state_d = S_FETCH;
                    error_d = 1'b1;
                end
            end
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_AEX:    state_d = S_AWB;
            S_AWB:    state_d = S_FETCH;
            S_JMP:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode (BEQ pc_en follows zero, REX alu_ctrl follows funct).
    always_comb begin
        pc_en_s      = 1'b0;
        ir_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        iord_s       = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_src_s     = 2'b00;
        alu_ctrl_s   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_s  = 1'b1;
                pc_en_s     = 1'b1;
                alu_src_b_s = 2'b01;
            end
            S_DECODE: alu_src_b_s = 2'b11;
            S_MEMADR, S_AEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEMRD: iord_s = 1'b1;
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEMWR: begin
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
            end
`ifdef MC_CTRL_IO_WAIT_EN
            S_IOWAIT: begin
                iord_s      = 1'b1;
                mem_write_s = (op == OP_SW);
            end
`endif
            S_REX: begin
                alu_src_a_s = 1'b1;
                alu_ctrl_s  = funct_to_alu(funct);
            end
            S_RWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s = 1'b1;
                alu_ctrl_s  = ALU_SUB;
                pc_src_s    = 2'b01;
                pc_en_s     = zero;
            end
            S_AWB: reg_write_s = 1'b1;
            S_JMP: begin
                pc_src_s = 2'b10;
                pc_en_s  = 1'b1;
            end
            default: begin
                pc_en_s = 1'b0;
            end
        endcase
    end

    // Write enables are forced off while reset is held.
    assign pc_en      = pc_en_s & reset_n;
    assign ir_write   = ir_write_s & reset_n;
    assign mem_write  = mem_write_s & reset_n;
    assign reg_write  = reg_write_s & reset_n;
    assign iord       = iord_s;
    assign reg_dst    = reg_dst_s;
    assign mem_to_reg = mem_to_reg_s;
    assign alu_src_a  = alu_src_a_s;
    assign alu_src_b  = alu_src_b_s;
    assign pc_src     = pc_src_s;
    assign alu_ctrl   = alu_ctrl_s;
    assign error      = error_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes hand-written expected
// per-cycle output vectors; a negedge monitor pops and compares them.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
`ifdef MC_CTRL_IO_WAIT_EN
    logic       is_io = 1'b0;
    logic       io_ready = 1'b0;
`endif
    logic       pc_en, ir_write, mem_write, reg_write;
    logic       iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_ctrl, state;
    logic       error;

    mc_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
`ifdef MC_CTRL_IO_WAIT_EN
        .is_io(is_io), .io_ready(io_ready),
`endif
        .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .iord(iord), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_ctrl(alu_ctrl), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    // Vector layout: state, pc_en, ir_write, mem_write, reg_write, iord,
    // reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctrl, error
    logic [20:0] act;
    assign act = {state, pc_en, ir_write, mem_write, reg_write, iord, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_ctrl, error};

    localparam logic [19:0] E_RST   = {4'd0,  8'b0000_0000, 2'b01, 2'b00, 4'b0000};
    localparam logic [19:0] E_FETCH = {4'd0,  8'b1100_0000, 2'b01, 2'b00, 4'b0000};
    localparam logic [19:0] E_DEC   = {4'd1,  8'b0000_0000, 2'b11, 2'b00, 4'b0000};
    localparam logic [19:0] E_MADR  = {4'd2,  8'b0000_0001, 2'b10, 2'b00, 4'b0000};
    localparam logic [19:0] E_MRD   = {4'd3,  8'b0000_1000, 2'b00, 2'b00, 4'b0000};
    localparam logic [19:0] E_MWB   = {4'd4,  8'b0001_0010, 2'b00, 2'b00, 4'b0000};
    localparam logic [19:0] E_MWR   = {4'd5,  8'b0010_1000, 2'b00, 2'b00, 4'b0000};
    localparam logic [19:0] E_RWB   = {4'd7,  8'b0001_0100, 2'b00, 2'b00, 4'b0000};
    localparam logic [19:0] E_AEX   = {4'd9,  8'b0000_0001, 2'b10, 2'b00, 4'b0000};
    localparam logic [19:0] E_AWB   = {4'd10, 8'b0001_0000, 2'b00, 2'b00, 4'b0000};
    localparam logic [19:0] E_JMP   = {4'd11, 8'b1000_0000, 2'b00, 2'b10, 4'b0000};
    localparam logic [19:0] E_IOWSW = {4'd12, 8'b0010_1000, 2'b00, 2'b00, 4'b0000};
    localparam logic [19:0] E_IOWLW = {4'd12, 8'b0000_1000, 2'b00, 2'b00, 4'b0000};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010;

    typedef struct {
        logic [20:0] v;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_pushed = 0;
    logic exp_err = 1'b0;

    function automatic logic [19:0] e_rex(input logic [3:0] alu);
        return {4'd6, 8'b0000_0001, 2'b00, 2'b00, alu};
    endfunction

    function automatic logic [19:0] e_beq(input logic z);
        return {4'd8, z, 7'b000_0001, 2'b00, 2'b01, 4'b0010};
    endfunction

    task automatic check(input logic [20:0] exp, input int id);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d: got %b required %b (t=%0t)", id, act, exp, $time);
        end
    endtask

    task automatic push(input logic [19:0] b);
        exp_t e;
        e.v = {b, exp_err};
        e.id = n_pushed;
        n_pushed++;
        sb_q.push_back(e);
    endtask

    // Apply one instruction for n cycles; called and returns at posedge+1.
    task automatic go(input logic [5:0] o, input logic [5:0] f, input logic z, input int n);
        op = o;
        funct = f;
        zero = z;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_err = 1'b0;
        push(E_RST);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: outputs are valid every cycle, compare one entry per negedge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(e.v, e.id);
        end
    end

    logic [5:0] fn_tab [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b100110, 6'b100111, 6'b101010};
    logic [3:0] alu_tab[7] = '{4'b0000, 4'b0010, 4'b0100, 4'b0101,
                               4'b0110, 4'b0111, 4'b1010};

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // lw: 0,1,2,3,4
        push(E_FETCH); push(E_DEC); push(E_MADR); push(E_MRD); push(E_MWB);
        go(LW, 6'd0, 1'b0, 5);
        // sw: 0,1,2,5
        push(E_FETCH); push(E_DEC); push(E_MADR); push(E_MWR);
        go(SW, 6'd0, 1'b0, 4);
        // R-type, every legal funct
        for (int i = 0; i < 7; i++) begin
            push(E_FETCH); push(E_DEC); push(e_rex(alu_tab[i])); push(E_RWB);
            go(RT, fn_tab[i], 1'b0, 4);
        end
        // beq taken / not taken
        push(E_FETCH); push(E_DEC); push(e_beq(1'b1));
        go(BQ, 6'd0, 1'b1, 3);
        push(E_FETCH); push(E_DEC); push(e_beq(1'b0));
        go(BQ, 6'd0, 1'b0, 3);
        // addi, j
        push(E_FETCH); push(E_DEC); push(E_AEX); push(E_AWB);
        go(AI, 6'd0, 1'b0, 4);
        push(E_FETCH); push(E_DEC); push(E_JMP);
        go(JJ, 6'd0, 1'b0, 3);

`ifdef MC_CTRL_IO_WAIT_EN
        // lw with is_io and io_ready together: no stall
        is_io = 1'b1; io_ready = 1'b1;
        push(E_FETCH); push(E_DEC); push(E_MADR); push(E_MRD); push(E_MWB);
        go(LW, 6'd0, 1'b0, 5);
        // lw stalled one cycle
        io_ready = 1'b0;
        push(E_FETCH); push(E_DEC); push(E_MADR); push(E_MRD); push(E_IOWLW); push(E_MWB);
        go(LW, 6'd0, 1'b0, 4);
        io_ready = 1'b1;
        go(LW, 6'd0, 1'b0, 2);
        // sw with io_ready low for 3 cycles: mem_write held 4 cycles
        io_ready = 1'b0;
        push(E_FETCH); push(E_DEC); push(E_MADR); push(E_MWR);
        push(E_IOWSW); push(E_IOWSW); push(E_IOWSW);
        go(SW, 6'd0, 1'b0, 6);
        io_ready = 1'b1;
        go(SW, 6'd0, 1'b0, 1);
        // sw timeout: 16 IOWAIT cycles then FETCH with error
        io_ready = 1'b0;
        push(E_FETCH); push(E_DEC); push(E_MADR); push(E_MWR);
        for (int i = 0; i < 16; i++) push(E_IOWSW);
        go(SW, 6'd0, 1'b0, 20);
        is_io = 1'b0;
        exp_err = 1'b1;
        push(E_FETCH); push(E_DEC); push(E_JMP);
        go(JJ, 6'd0, 1'b0, 3);
        do_reset();
`endif

        // unknown funct: add in REX, no RWB, error set afterwards
        push(E_FETCH); push(E_DEC); push(e_rex(4'b0000));
        go(RT, 6'b111111, 1'b0, 3);
        exp_err = 1'b1;
        push(E_FETCH); push(E_DEC); push(E_JMP);
        go(JJ, 6'd0, 1'b0, 3);
        do_reset();

        // illegal opcode: DECODE -> FETCH, error sticky through a valid addi
        push(E_FETCH); push(E_DEC);
        go(6'b111111, 6'd0, 1'b0, 2);
        exp_err = 1'b1;
        push(E_FETCH); push(E_DEC); push(E_AEX); push(E_AWB);
        go(AI, 6'd0, 1'b0, 4);

        // reset pulse while in MEMWR
        push(E_FETCH); push(E_DEC); push(E_MADR); push(E_MWR);
        go(SW, 6'd0, 1'b0, 3);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        exp_err = 1'b0;
        #1;
        check({E_RST, 1'b0}, 9000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // clean lw after reset
        push(E_FETCH); push(E_DEC); push(E_MADR); push(E_MRD); push(E_MWB);
        go(LW, 6'd0, 1'b0, 5);

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
